xlr8_text_render: RTL and testbench
===================================

Name: xlr8_text_render

Overview:
- Pixel-side text-mode renderer: the stage directly downstream of the character/attribute dual-port RAMs, consuming port B of both.
- Takes raster counters and syncs from the video timing generator and computes the 80x30 character-cell RAM address, applying hardware row scroll.
- Looks up the 8x16 glyph in the font ROM, applies foreground/background/blink attributes, and emits 24-bit RGB with delay-matched syncs to the TMDS encoder.

Parameters:
- COLS, 80, characters per row (640/8).
- ROWS, 30, character rows (480/16).
- BLINK_LOG2, 5, blink phase = frame counter bit BLINK_LOG2-1 (toggles every 16 frames).

Ports:
- clk_pixel  in  1  pixel clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cx  in  10  raster column, 0..639 valid while de_in=1.
- cy  in  10  raster line, 0..479 valid while de_in=1.
- de_in  in  1  active-video flag from timing generator.
- hsync_in  in  1  horizontal sync (polarity passed through untouched).
- vsync_in  in  1  vertical sync (polarity passed through; rising edge counts frames).
- row_offset  in  8  scroll offset in character rows (RAM_ROW_OFFSET register).
- ram_address  out  13  character/attribute RAM port-B address.
- ram_re  out  1  port-B read enable.
- ram_char_data  in  8  character code; valid 1 cycle after ram_re.
- ram_attr_data  in  8  attribute; valid 1 cycle after ram_re.
- font_addr  out  12  font ROM address = {char[7:0], glyph_row[3:0]}.
- font_data  in  8  glyph row bits, MSB = leftmost pixel; valid 1 cycle after font_addr.
- rgb  out  24  {R[7:0],G[7:0],B[7:0]}.
- de_out, hsync_out, vsync_out  out  1 each  de_in/hsync_in/vsync_in delayed to align with rgb.

Behaviour:
Reset:
- Every register clears, including the pipeline delay lines and the frame counter.
- rgb=0, de_out=0, hsync_out=0, vsync_out=0, ram_re=0, ram_address=0, font_addr=0.
- Reset asserted mid-frame clears the pipeline. Outputs stay 0 until valid data drains through 4 cycles after release; no partial glyphs.

Pipeline: fixed latency of 4 clk_pixel cycles from inputs to rgb/de_out/hsync_out/vsync_out.
- S1 (edge 1): register ram_address and ram_re=de_in. Carry cx[2:0], cy[3:0], de, hs, vs.
  - eff_off = row_offset if row_offset<ROWS, else 0.
  - row = cy[8:4] + eff_off; subtract ROWS if the sum is >= ROWS (result 0..29).
  - ram_address = row*COLS + cx[9:3], range 0..2399.
- S2 (edge 2): RAM q valid. Register font_addr={ram_char_data, cy[3:0] delayed}. Latch attr; carry cx[2:0].
- S3 (edge 3): font_data valid. Register pixel bit = font_data[7 - cx[2:0] delayed]. Carry attr.
- S4 (edge 4): register outputs.
  - If de delayed=0: rgb=0.
  - Else: fg=attr[3:0], bg={1'b0,attr[6:4]}.
  - If attr[7]=1 and blink_phase=1, fg is replaced by bg.
  - rgb = palette(pixel ? fg : bg).
- ram_re is low whenever de_in=0. RAM addresses outside 0..2399 are never issued.

Palette (index i = {I,R,G,B}):
- Each component = (bit ? 0xAA : 0x00) + (I ? 0x55 : 0x00).
- Exception: index 6 has G=0x55 (brown).
- Index 7 = AAAAAA, 8 = 555555, 15 = FFFFFF.

Blink:
- frame_cnt (BLINK_LOG2 bits) increments on each vsync_in 0->1 transition (registered edge detect) and wraps from all-ones to 0.
- blink_phase = frame_cnt[BLINK_LOG2-1]. It changes only on a vsync edge, so it never changes mid-line.

Boundaries:
- row_offset change mid-frame takes effect on the next S1 cycle. No shadowing; software writes during vblank.
- row_offset=29 with cy row 1 gives row 0 (wrap).
- cx/cy outside the active area with de_in=0 produce no RAM read and black output.

Test Plan:
- Reset: hold rst 3 cycles mid-line with de_in=1 -> rgb=0, de_out=0, ram_re=0 during reset and for 4 cycles after release.
- Addressing: cx=639, cy=479, row_offset=0 -> ram_address=2399 one cycle later. With row_offset=1, same cx/cy -> 79. With row_offset=45 -> treated as 0 -> 2399.
- Glyph/colour: RAM char 0x41, attr 0x1E, font_data=0x80 at glyph row 5, cy=5, cx=0..7 -> font_addr=0x415. Pixel 0 rgb=FFFF55 (yellow), pixels 1..7 rgb=0000AA, each 4 cycles after the corresponding cx.
- Latency/syncs: pulse hsync_in and vsync_in for one cycle with de_in toggling -> hsync_out/vsync_out/de_out reproduce the identical waveforms delayed exactly 4 cycles.
- Blink: attr 0x8F, pixel=1 -> rgb=FFFFFF for frames 0..15. After the 16th vsync rising edge -> rgb=000000 (bg 0). Back to FFFFFF after the 32nd edge.
- Blanking: de_in=0 with non-zero RAM/font data -> rgb=0 and ram_re=0.

Source files
------------

// File: rtl/xlr8_text_render.sv
// Text-mode pixel renderer: maps the raster position to a character cell, then
// does the glyph lookup and palette mapping over a fixed 4-cycle pipeline.
module xlr8_text_render #(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int BLINK_LOG2 = 5
) (
    input  logic        clk_pixel,
    input  logic        rst,
    input  logic [9:0]  cx,
    input  logic [9:0]  cy,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [7:0]  row_offset,
    output logic [12:0] ram_address,
    output logic        ram_re,
    input  logic [7:0]  ram_char_data,
    input  logic [7:0]  ram_attr_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [23:0] rgb,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out
);
    localparam logic [7:0]  ROWS_B = 8'(ROWS);
    localparam logic [6:0]  ROWS_W = 7'(ROWS);
    localparam logic [12:0] COLS_W = 13'(COLS);

    // S1 combinational address: scroll-wrapped character row times row pitch
    logic [4:0]  w_eff_off;
    logic [6:0]  w_row_sum;
    logic [6:0]  w_row;
    logic [12:0] w_addr;

    always_comb begin
        w_eff_off = (row_offset < ROWS_B) ? row_offset[4:0] : 5'd0;
        w_row_sum = {1'b0, cy[9:4]} + {2'b00, w_eff_off};
        w_row     = (w_row_sum >= ROWS_W) ? (w_row_sum - ROWS_W) : w_row_sum;
        w_addr    = {6'd0, w_row} * COLS_W + {6'd0, cx[9:3]};
    end

    // Pipeline registers, one group per stage
    logic [12:0] r_ram_address;
    logic        r_ram_re;
    logic [2:0]  r_s1_cx;
    logic [3:0]  r_s1_cy;
    logic        r_s1_de, r_s1_hs, r_s1_vs;

    logic [11:0] r_font_addr;
    logic [7:0]  r_s2_attr;
    logic [2:0]  r_s2_cx;
    logic        r_s2_de, r_s2_hs, r_s2_vs;

    logic        r_s3_pix;
    logic [7:0]  r_s3_attr;
    logic        r_s3_de, r_s3_hs, r_s3_vs;

    logic [23:0] r_rgb;
    logic        r_de_out, r_hs_out, r_vs_out;

    logic                  r_vs_prev;
    logic [BLINK_LOG2-1:0] r_frame_cnt;

    logic        w_vs_rise;
    logic        w_blink;
    logic [2:0]  w_bit_sel;
    logic [3:0]  w_fg;
    logic [3:0]  w_bg;
    logic [3:0]  w_color;
    logic [23:0] w_rgb;

    function automatic logic [23:0] palette(input logic [3:0] idx);
        logic [23:0] c;
        case (idx)
            4'd1:    c = 24'h0000AA;
            4'd2:    c = 24'h00AA00;
            4'd3:    c = 24'h00AAAA;
            4'd4:    c = 24'hAA0000;
            4'd5:    c = 24'hAA00AA;
            4'd6:    c = 24'hAA5500;
            4'd7:    c = 24'hAAAAAA;
            4'd8:    c = 24'h555555;
            4'd9:    c = 24'h5555FF;
            4'd10:   c = 24'h55FF55;
            4'd11:   c = 24'h55FFFF;
            4'd12:   c = 24'hFF5555;
            4'd13:   c = 24'hFF55FF;
            4'd14:   c = 24'hFFFF55;
            4'd15:   c = 24'hFFFFFF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    always_comb begin
        w_vs_rise = vsync_in & ~r_vs_prev;
        w_blink   = r_frame_cnt[BLINK_LOG2-1];
        w_bit_sel = 3'd7 - r_s2_cx;
        w_fg      = r_s3_attr[3:0];
        w_bg      = {1'b0, r_s3_attr[6:4]};
        if (r_s3_attr[7] && w_blink) begin
            w_fg = w_bg;
        end
        w_color = r_s3_pix ? w_fg : w_bg;
        w_rgb   = r_s3_de ? palette(w_color) : 24'h000000;
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            r_ram_address <= 13'd0;
            r_ram_re      <= 1'b0;
            r_s1_cx       <= 3'd0;
            r_s1_cy       <= 4'd0;
            r_s1_de       <= 1'b0;
            r_s1_hs       <= 1'b0;
            r_s1_vs       <= 1'b0;
            r_font_addr   <= 12'd0;
            r_s2_attr     <= 8'd0;
            r_s2_cx       <= 3'd0;
            r_s2_de       <= 1'b0;
            r_s2_hs       <= 1'b0;
            r_s2_vs       <= 1'b0;
            r_s3_pix      <= 1'b0;
            r_s3_attr     <= 8'd0;
            r_s3_de       <= 1'b0;
            r_s3_hs       <= 1'b0;
            r_s3_vs       <= 1'b0;
            r_rgb         <= 24'd0;
            r_de_out      <= 1'b0;
            r_hs_out      <= 1'b0;
            r_vs_out      <= 1'b0;
            r_vs_prev     <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            // Address only moves during active video so blanking never
            // presents an out-of-range cell to the RAM.
            if (de_in) begin
                r_ram_address <= w_addr;
            end
            r_ram_re    <= de_in;
            r_s1_cx     <= cx[2:0];
            r_s1_cy     <= cy[3:0];
            r_s1_de     <= de_in;
            r_s1_hs     <= hsync_in;
            r_s1_vs     <= vsync_in;

            r_font_addr <= {ram_char_data, r_s1_cy};
            r_s2_attr   <= ram_attr_data;
            r_s2_cx     <= r_s1_cx;
            r_s2_de     <= r_s1_de;
            r_s2_hs     <= r_s1_hs;
            r_s2_vs     <= r_s1_vs;

            r_s3_pix    <= font_data[w_bit_sel];
            r_s3_attr   <= r_s2_attr;
            r_s3_de     <= r_s2_de;
            r_s3_hs     <= r_s2_hs;
            r_s3_vs     <= r_s2_vs;

            r_rgb       <= w_rgb;
            r_de_out    <= r_s3_de;
            r_hs_out    <= r_s3_hs;
            r_vs_out    <= r_s3_vs;

            r_vs_prev   <= vsync_in;
            if (w_vs_rise) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign ram_address = r_ram_address;
    assign ram_re      = r_ram_re;
    assign font_addr   = r_font_addr;
    assign rgb         = r_rgb;
    assign de_out      = r_de_out;
    assign hsync_out   = r_hs_out;
    assign vsync_out   = r_vs_out;

endmodule

// File: tb/tb_xlr8_text_render.sv
// Bench for xlr8_text_render: RAM/font models, directed cases and a random
// phase, all compared cycle by cycle against a cell/glyph/palette model.
module tb_xlr8_text_render;

    logic        clk_pixel = 1'b0;
    logic        rst;
    logic [9:0]  cx;
    logic [9:0]  cy;
    logic        de_in;
    logic        hsync_in;
    logic        vsync_in;
    logic [7:0]  row_offset;
    logic [12:0] ram_address;
    logic        ram_re;
    logic [7:0]  ram_char_data;
    logic [7:0]  ram_attr_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic [23:0] rgb;
    logic        de_out;
    logic        hsync_out;
    logic        vsync_out;

    // ---------------- clock ----------------
    always #5 clk_pixel = ~clk_pixel;

    // ---------------- memories seen by the DUT ----------------
    logic [7:0] char_mem [0:8191];
    logic [7:0] attr_mem [0:8191];
    logic [7:0] font_mem [0:4095];

    assign ram_char_data = char_mem[ram_address];
    assign ram_attr_data = attr_mem[ram_address];
    assign font_data     = font_mem[font_addr];

    xlr8_text_render dut (
        .clk_pixel     (clk_pixel),
        .rst           (rst),
        .cx            (cx),
        .cy            (cy),
        .de_in         (de_in),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .row_offset    (row_offset),
        .ram_address   (ram_address),
        .ram_re        (ram_re),
        .ram_char_data (ram_char_data),
        .ram_attr_data (ram_attr_data),
        .font_addr     (font_addr),
        .font_data     (font_data),
        .rgb           (rgb),
        .de_out        (de_out),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [23:0] rgb_log  [0:8191];
    logic        de_log   [0:8191];
    logic        hs_log   [0:8191];
    logic        vs_log   [0:8191];
    logic        re_log   [0:8191];
    logic [12:0] addr_log [0:8191];
    logic [11:0] font_log [0:8191];

    typedef struct packed {
        logic       rst;
        logic [9:0] cx;
        logic [9:0] cy;
        logic       de;
        logic       hs;
        logic       vs;
        logic [7:0] ro;
    } samp_t;

    samp_t      hist [0:3];
    logic [4:0] fc = 5'd0;
    logic       vs_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int model_addr(input logic [9:0] x, input logic [9:0] y, input logic [7:0] ro);
        int eff;
        eff = (int'(ro) < 30) ? int'(ro) : 0;
        return ((int'(y) / 16 + eff) % 30) * 80 + int'(x) / 8;
    endfunction

    function automatic logic [23:0] pal(input logic [3:0] i);
        logic [7:0] r, g, b;
        r = (i[2] ? 8'hAA : 8'h00) + (i[3] ? 8'h55 : 8'h00);
        g = (i[1] ? 8'hAA : 8'h00) + (i[3] ? 8'h55 : 8'h00);
        b = (i[0] ? 8'hAA : 8'h00) + (i[3] ? 8'h55 : 8'h00);
        if (i == 4'd6) g = 8'h55;
        return {r, g, b};
    endfunction

    function automatic logic [23:0] exp_pixel(input samp_t s, input logic [4:0] frames);
        int a;
        int bit_i;
        logic [7:0] ch, at, fb;
        logic [3:0] fg, bg;
        logic pix;
        if (!s.de) return 24'h000000;
        a     = model_addr(s.cx, s.cy, s.ro);
        ch    = char_mem[a];
        at    = attr_mem[a];
        fb    = font_mem[{ch, s.cy[3:0]}];
        bit_i = 7 - int'(s.cx[2:0]);
        pix   = fb[bit_i];
        fg    = at[3:0];
        bg    = {1'b0, at[6:4]};
        if (at[7] && frames[4]) fg = bg;
        return pal(pix ? fg : bg);
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            hist[i]     = '0;
            hist[i].rst = 1'b1;
        end
    end

    // One compare process: every cycle, outputs vs. model built from sampled inputs
    always @(posedge clk_pixel) begin
        logic        any_rst;
        logic [23:0] e_rgb;
        logic        e_de, e_hs, e_vs, e_re;
        logic        chk_addr, chk_font;
        logic [12:0] e_addr;
        logic [11:0] e_font;
        int          a1;

        cyc++;
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = '{rst: rst, cx: cx, cy: cy, de: de_in, hs: hsync_in, vs: vsync_in, ro: row_offset};

        any_rst = hist[0].rst | hist[1].rst | hist[2].rst | hist[3].rst;
        e_rgb   = any_rst ? 24'h0 : exp_pixel(hist[3], fc);
        e_de    = any_rst ? 1'b0 : hist[3].de;
        e_hs    = any_rst ? 1'b0 : hist[3].hs;
        e_vs    = any_rst ? 1'b0 : hist[3].vs;
        e_re    = !hist[0].rst && hist[0].de;

        chk_addr = hist[0].rst || e_re;
        e_addr   = hist[0].rst ? 13'd0 : 13'(model_addr(hist[0].cx, hist[0].cy, hist[0].ro));
        chk_font = hist[0].rst || (!hist[1].rst && hist[1].de);
        a1       = model_addr(hist[1].cx, hist[1].cy, hist[1].ro);
        e_font   = hist[0].rst ? 12'd0 : {char_mem[a1], hist[1].cy[3:0]};

        if (hist[0].rst) begin
            fc      = 5'd0;
            vs_prev = 1'b0;
        end else begin
            if (hist[0].vs && !vs_prev) fc = fc + 5'd1;
            vs_prev = hist[0].vs;
        end

        #1;
        chk("rgb", rgb, e_rgb);
        chk("de_out", de_out, e_de);
        chk("hsync_out", hsync_out, e_hs);
        chk("vsync_out", vsync_out, e_vs);
        chk("ram_re", ram_re, e_re);
        if (chk_addr) chk("ram_address", ram_address, e_addr);
        if (chk_font) chk("font_addr", font_addr, e_font);

        rgb_log[cyc]  = rgb;
        de_log[cyc]   = de_out;
        hs_log[cyc]   = hsync_out;
        vs_log[cyc]   = vsync_out;
        re_log[cyc]   = ram_re;
        addr_log[cyc] = ram_address;
        font_log[cyc] = font_addr;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic r, input logic d, input int x, input int y,
                        input logic h, input logic v, output int k);
        @(negedge clk_pixel);
        rst      = r;
        de_in    = d;
        cx       = 10'(x);
        cy       = 10'(y);
        hsync_in = h;
        vsync_in = v;
        k        = cyc + 1;
    endtask

    task automatic idle(input int n);
        int k;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, k);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int kr [0:2];
        int ka;
        int kg [0:7];
        int ks [0:7];
        int kd;
        logic ds [0:7];

        rst = 1'b1; de_in = 1'b0; cx = '0; cy = '0;
        hsync_in = 1'b0; vsync_in = 1'b0; row_offset = 8'd0;
        for (int i = 0; i < 8192; i++) begin
            char_mem[i] = 8'($urandom);
            attr_mem[i] = 8'($urandom);
        end
        for (int i = 0; i < 4096; i++) font_mem[i] = 8'($urandom);

        // Reset after power-up, then reset mid-line
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, k);
        idle(4);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, i * 8, 40, 1'b0, 1'b0, k);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 40 + i * 8, 40, 1'b0, 1'b0, kr[i]);
        step(1'b0, 1'b1, 64, 40, 1'b0, 1'b0, ka);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 72 + i * 8, 40, 1'b0, 1'b0, k);
        idle(5);
        chk("rst_de_during", de_log[kr[0]], 1'b0);
        chk("rst_re_during", re_log[kr[1]], 1'b0);
        chk("rst_rgb_drain", rgb_log[ka + 2], 24'h0);
        chk("rst_de_drain", de_log[ka + 2], 1'b0);
        chk("rst_de_first", de_log[ka + 3], 1'b1);

        // Addressing and scroll
        row_offset = 8'd0;
        step(1'b0, 1'b1, 639, 479, 1'b0, 1'b0, k);
        idle(1);
        chk("addr_off0", addr_log[k], 13'd2399);
        row_offset = 8'd1;
        step(1'b0, 1'b1, 639, 479, 1'b0, 1'b0, k);
        idle(1);
        chk("addr_off1", addr_log[k], 13'd79);
        row_offset = 8'd45;
        step(1'b0, 1'b1, 639, 479, 1'b0, 1'b0, k);
        idle(1);
        chk("addr_off45", addr_log[k], 13'd2399);
        row_offset = 8'd29;
        step(1'b0, 1'b1, 3, 20, 1'b0, 1'b0, k);
        idle(1);
        chk("addr_wrap", addr_log[k], 13'd0);
        row_offset = 8'd0;
        idle(5);

        // Glyph and colour
        char_mem[0] = 8'h41;
        attr_mem[0] = 8'h1E;
        font_mem[12'h415] = 8'h80;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, i, 5, 1'b0, 1'b0, kg[i]);
        idle(5);
        chk("glyph_font_addr", font_log[kg[0] + 1], 12'h415);
        chk("glyph_px0", rgb_log[kg[0] + 3], 24'hFFFF55);
        for (int i = 1; i < 8; i++) chk("glyph_bg", rgb_log[kg[i] + 3], 24'h0000AA);

        // Syncs and de delayed 4 cycles
        for (int i = 0; i < 8; i++) begin
            ds[i] = (i % 3) != 1;
            step(1'b0, ds[i], i * 8, 100, i == 2, i == 5, ks[i]);
        end
        idle(5);
        chk("hs_pre", hs_log[ks[2] + 2], 1'b0);
        chk("hs_pulse", hs_log[ks[2] + 3], 1'b1);
        chk("hs_post", hs_log[ks[2] + 4], 1'b0);
        chk("vs_pulse", vs_log[ks[5] + 3], 1'b1);
        chk("vs_post", vs_log[ks[5] + 4], 1'b0);
        for (int i = 0; i < 8; i++) chk("de_delay", de_log[ks[i] + 3], ds[i]);

        // Blanking with live RAM/font contents
        step(1'b0, 1'b0, 0, 5, 1'b0, 1'b0, kd);
        idle(5);
        chk("blank_re", re_log[kd], 1'b0);
        chk("blank_rgb", rgb_log[kd + 3], 24'h0);

        // Blink over 33 frames
        char_mem[0] = 8'h10;
        attr_mem[0] = 8'h8F;
        font_mem[12'h100] = 8'hFF;
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, k);
        idle(2);
        for (int f = 0; f <= 32; f++) begin
            step(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, k);
            idle(4);
            chk("blink", rgb_log[k + 3], (f >= 16 && f < 32) ? 24'h000000 : 24'hFFFFFF);
            step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, kd);
        end
        idle(5);

        // Random traffic against the model
        for (int i = 0; i < 8192; i++) begin
            char_mem[i] = 8'($urandom);
            attr_mem[i] = 8'($urandom);
        end
        for (int i = 0; i < 4096; i++) font_mem[i] = 8'($urandom);
        for (int i = 0; i < 3000; i++) begin
            logic d;
            if ($urandom_range(0, 49) == 0) row_offset = 8'($urandom_range(0, 63));
            d = $urandom_range(0, 3) != 0;
            step($urandom_range(0, 199) == 0, d,
                 d ? $urandom_range(0, 639) : $urandom_range(0, 1023),
                 d ? $urandom_range(0, 479) : $urandom_range(0, 1023),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, k);
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
